updown_sweep_ctrl: RTL

Sequencing controller for the 2-bit up/down counter datapath. On `start`, it drives a counter through a configurable number of triangle sweeps: count up 0→`limit`, dwell at the peak, count down `limit`→0. It owns the counter instance, generates its direction and enable, and reports progress to the surrounding control logic. Typical clients are test-pattern and ramp generators that need a bounded, repeatable counter excursion.

---
 rtl/updown_pkg.sv | 12 +
 rtl/up_down_counter_en.sv | 22 ++
 rtl/updown_sweep_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/updown_pkg.sv
// updown_pkg: shared state encoding and direction constants for the sweep controller
package updown_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP   = 3'd1,
        HOLD = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } sweep_state_t;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/up_down_counter_en.sv
// up_down_counter_en: up/down counter with enable and synchronous clear
//   clk, reset (async active-low), en, clr (sync, wins over en), up_down (1=up), q
module up_down_counter_en
    import updown_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             up_down,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= (up_down == DIR_UP) ? q + 1'b1 : q - 1'b1;
endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives a counter through N triangle sweeps 0->limit->dwell->0
//   in : clk, reset (async active-low), start, abort, limit, num_sweeps
//   out: q, up_down, cnt_en, sweep_idx, busy, done
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int SWEEPS_W = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    limit,
    input  logic [SWEEPS_W-1:0] num_sweeps,
    output logic [WIDTH-1:0]    q,
    output logic                up_down,
    output logic                cnt_en,
    output logic [SWEEPS_W-1:0] sweep_idx,
    output logic                busy,
    output logic                done
);
    localparam int HC_W = $clog2(HOLD_CYC + 1);
    sweep_state_t        state;
    logic [WIDTH-1:0]    limit_r;
    logic [SWEEPS_W-1:0] num_r;
    logic [HC_W-1:0]     hold_cnt;
    // Moore decode: the counter only moves while it has not reached its end point
    assign cnt_en  = (state == UP && q != limit_r) || (state == DOWN && q != '0);
    assign up_down = (state == DOWN) ? DIR_DOWN : DIR_UP;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    up_down_counter_en #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .en      (cnt_en),
        .clr     (abort),
        .up_down (up_down),
        .q       (q)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            limit_r   <= '0;
            num_r     <= '0;
            sweep_idx <= '0;
            hold_cnt  <= '0;
        end else if (abort) begin
            state     <= IDLE;
            sweep_idx <= '0;
        end else
            case (state)
                IDLE:
                    if (start) begin
                        limit_r   <= limit;
                        num_r     <= num_sweeps;
                        sweep_idx <= '0;
                        state     <= (limit != '0 && num_sweeps != '0) ? UP : DONE;
                    end
                UP:
                    if (q == limit_r) begin
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                HOLD:
                    if (hold_cnt == HC_W'(HOLD_CYC - 1))
                        state <= DOWN;
                    else
                        hold_cnt <= hold_cnt + 1'b1;
                DOWN:
                    if (q == '0) begin
                        // num_r is nonzero here, so num_r-1 is the last index
                        if (sweep_idx == num_r - 1'b1)
                            state <= DONE;
                        else begin
                            sweep_idx <= sweep_idx + 1'b1;
                            state     <= UP;
                        end
                    end
                DONE:
                    state <= IDLE;
                default:
                    state <= IDLE;
            endcase
endmodule
